// File: rtl/ksort_reader_if.sv
// Result stream from the k-sort reader to the downstream collector.
// One beat per sorted entry, carrying rank and last flag.
interface ksort_reader_if #(
  parameter int dataWidth = 32
);
  logic                 m_valid;
  logic                 m_ready;
  logic [31:0]          m_name;
  logic [dataWidth-1:0] m_value;
  logic [31:0]          m_index;
  logic                 m_last;

  modport master (
    output m_valid, m_name, m_value, m_index, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_name, m_value, m_index, m_last,
    output m_ready
  );
endinterface

// File: rtl/ksort_reader.sv
// Drains the k smallest entries from the insertion sorter in ascending order
// and presents them one at a time on a valid/ready stream.
module ksort_reader #(
  parameter int dataWidth = 32,
  parameter int maxMemory = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          k,
  output logic                 srt_done,
  output logic                 srt_rd_en,
  output logic [31:0]          srt_k,
  input  logic [31:0]          srt_name,
  input  logic [dataWidth-1:0] srt_value,
  ksort_reader_if.master       m_if,
  output logic                 busy,
  output logic                 finished
);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, PRESENT, ADV1, ADV2, FINISH, HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          kc_q, kc_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [31:0]          name_q, name_d;
  logic [dataWidth-1:0] value_q, value_d;
  logic [31:0]          index_q, index_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 fin_q, fin_d;
  logic [31:0]          k_clamp;

  assign k_clamp = (k > 32'(maxMemory)) ? 32'(maxMemory) : k;

  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    name_d  = name_q;
    value_d = value_q;
    index_d = index_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (start) begin
        kc_d    = k_clamp;
        cnt_d   = '0;
        state_d = (k_clamp == '0) ? FINISH : CAPTURE;
      end
      CAPTURE: begin
        name_d  = srt_name;
        value_d = srt_value;
        index_d = cnt_q;
        last_d  = (cnt_q == kc_q - 32'd1);
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: if (valid_q && m_if.m_ready) begin
        valid_d = 1'b0;
        if (last_q) state_d = FINISH;
        else begin
          cnt_d   = cnt_q + 32'd1;
          state_d = ADV1;
        end
      end
      ADV1:    state_d = ADV2;
      // sorter pointer steps on the second rd_en cycle, so CAPTURE sees the new entry
      ADV2:    state_d = CAPTURE;
      FINISH:  state_d = HOLD;
      HOLD:    state_d = HOLD;
      default: state_d = IDLE;
    endcase
    // control outputs are registered by decoding the next state
    done_d  = (state_d != IDLE);
    rd_en_d = (state_d == ADV1) || (state_d == ADV2);
    busy_d  = (state_d == CAPTURE) || (state_d == PRESENT) ||
              (state_d == ADV1) || (state_d == ADV2);
    fin_d   = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kc_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      name_q  <= '0;
      value_q <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kc_q    <= kc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      name_q  <= name_d;
      value_q <= value_d;
      index_q <= index_d;
      last_q  <= last_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign srt_done       = done_q;
  assign srt_rd_en      = rd_en_q;
  assign srt_k          = kc_q;
  assign busy           = busy_q;
  assign finished       = fin_q;
  assign m_if.m_valid   = valid_q;
  assign m_if.m_name    = name_q;
  assign m_if.m_value   = value_q;
  assign m_if.m_index   = index_q;
  assign m_if.m_last    = last_q;

endmodule

// File: doc/ksort_reader.md
Name: ksort_reader

Overview:
- Read-side controller for the k-sorting insertion array.
- After loading is complete, it drives the sorter's done/rd_en/k inputs and samples its combinational name/value outputs.
- Emits the k smallest entries, in ascending order, as a valid/ready stream carrying index and last flag.
- Sits between the sorter and the downstream result collector.

Parameters:
- dataWidth, 32, width of sorter value bus and m_value.
- maxMemory, 128, sorter depth; upper clamp for k.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin draining; sampled only in IDLE
- k  input  32  number of results wanted; latched on accepted start
- srt_done  output  1  drives sorter done input
- srt_rd_en  output  1  drives sorter rd_en input
- srt_k  output  32  drives sorter k input; latched, clamped k
- srt_name  input  32  sorter dataNameOut
- srt_value  input  dataWidth  sorter dataValueOut
- m_valid  output  1  result beat valid
- m_ready  input  1  downstream accept
- m_name  output  32  registered entry ID
- m_value  output  dataWidth  registered entry value
- m_index  output  32  rank of beat, 0..kc-1
- m_last  output  1  high with final beat (m_index==kc-1)
- busy  output  1  high in CAPTURE/PRESENT/ADV1/ADV2
- finished  output  1  one-cycle pulse when drain completes

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0, including srt_k, m_*, busy and finished.
  - Internal counter = 0.
- Sorter read contract (fixed):
  - The sorter read pointer starts at 0 after reset.
  - With done=1, each pair of consecutive rd_en=1 cycles advances the pointer by one.
  - The first cycle of a pair arms; the second advances.
  - The pointer saturates at k-1.
  - Name/value track the pointer combinationally.
- k clamp: kc = min(k, maxMemory), latched on start. srt_k = kc.
- srt_done is 1 in every state except IDLE, and is cleared by reset.
- FSM:
  - IDLE:
    - start=1 and kc==0 -> FINISH.
    - start=1 and kc>0 -> CAPTURE.
    - start=0 -> stay.
  - CAPTURE (1 cycle):
    - srt_rd_en=0.
    - At the clock edge, m_name<=srt_name, m_value<=srt_value, m_index<=counter, m_last<=(counter==kc-1), m_valid<=1.
    - -> PRESENT.
  - PRESENT:
    - Hold m_valid and all m_* stable until m_valid&m_ready.
    - On handshake, m_valid<=0 on the same edge.
    - If the beat was last -> FINISH; else counter+1 -> ADV1.
  - ADV1: srt_rd_en=1 -> ADV2.
  - ADV2: srt_rd_en=1 -> CAPTURE. The pointer advances at the end of this cycle.
  - FINISH: finished=1 for exactly one cycle -> HOLD.
  - HOLD:
    - The drain is complete and the sorter pointer cannot be rewound.
    - start is ignored until reset.
    - srt_done stays 1; srt_rd_en stays 0.
- srt_rd_en is never asserted outside ADV1/ADV2; it is exactly 2 cycles per non-final beat.
- No ADV pulses follow the final beat, so the sorter pointer ends at kc-1.
- Latency:
  - First m_valid: 2 cycles after the start edge (IDLE->CAPTURE->PRESENT).
  - Between beats: handshake edge to next m_valid rise is 4 cycles.
  - With m_ready held high, throughput is 1 beat per 4 cycles.
- m_ready while m_valid=0 has no effect.
- start while busy is ignored. k changes after start are ignored.
- Reset mid-drain:
  - Immediate return to IDLE with all outputs cleared.
  - Sorter and reader are reset together by the shared reset.
- Empty sorter slots (value all-ones) are streamed like any other entry if kc exceeds the number loaded; no filtering.
- m_index width 32; the counter never exceeds kc-1, so there is no wrap.

Test Plan:
- Load sorter with values 50,10,30,20 (IDs 0..3), then start with k=3, m_ready=1 -> beats (name1,val10,idx0), (name3,val20,idx1), (name2,val30,idx2,last); finished 1 cycle after third handshake; srt_rd_en high for exactly 4 cycles total.
- Same load; start with k=2; m_ready held low 5 cycles on beat 0 -> m_valid and m_name=1/m_value=10 stable for all 5 cycles; srt_rd_en=0 throughout; beat 1 follows 4 cycles after the handshake.
- start with k=0 -> no m_valid ever; finished pulses 1 cycle after start edge; srt_rd_en never asserted.
- maxMemory=128, 128 values loaded, start with k=200 -> srt_k=128; 128 beats in ascending order; m_last only on idx127.
- After finished, pulse start again with k=4 -> ignored: no m_valid, busy=0, state stays HOLD; after reset plus reload, a new drain works.
- Assert reset during PRESENT of beat 1 -> next cycle m_valid=0, srt_done=0, busy=0, all m_*=0; a subsequent load and start with k=1 yields one beat, idx0, last.
